fpnew_share_ctrl: RTL

Shares a single `fpnew_top` instance between `NumReq` independent requesters, for example cores or hart contexts. It arbitrates issue round-robin and limits in-flight operations with an outstanding counter. It tags each operation with its requester index so the result returns only to that requester, and it sequences FPU flushes with a drain phase. It sits directly in front of `fpnew_top`, between the requesters and the FPU input/output handshakes.

---
 rtl/fpnew_share_ctrl_pkg.sv | 15 +
 rtl/fpnew_share_ctrl_rr_sel.sv | 25 ++
 rtl/fpnew_share_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fpnew_share_ctrl_pkg.sv
// Shared types and helpers for the fpnew_share_ctrl FPU sharing front-end.
package fpnew_share_ctrl_pkg;

    // Controller phase: normal issue/return, or discarding results after a flush.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } share_state_e;

    // Width of the tag sent through the FPU: {requester id, user tag}.
    function automatic int share_tag_width(input int num_req, input int user_tag_width);
        return $clog2(num_req) + user_tag_width;
    endfunction

endpackage

// File: rtl/fpnew_share_ctrl_rr_sel.sv
// Combinational round-robin selector: first requester at or above i_rr_ptr,
// wrapping around. The pointer register lives in the caller.
module fpnew_share_rr_sel #(
    parameter  int NumReq  = 4,
    localparam int IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  i_req,
    input  logic [IdWidth-1:0] i_rr_ptr,
    output logic [IdWidth-1:0] o_gnt_idx,
    output logic               o_gnt_valid
);

    // Scan offsets high to low so the smallest offset from the pointer wins.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (i_req[(int'(i_rr_ptr) + k) % NumReq]) begin
                o_gnt_idx   = IdWidth'((int'(i_rr_ptr) + k) % NumReq);
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpnew_share_ctrl.sv
// fpnew_share_ctrl: shares one FPU between NumReq requesters. Round-robin issue,
// outstanding-op limit, id-tagged response routing, flush with drain phase.
// Optional SVA checks are compiled in with FPNEW_SHARE_ASSERT_EN.
module fpnew_share_ctrl
    import fpnew_share_ctrl_pkg::*;
#(
    parameter  int  NumReq         = 4,
    parameter  type ReqType        = logic,
    parameter  type RspType        = logic,
    parameter  int  UserTagWidth   = 4,
    parameter  int  MaxOutstanding = 4,
    localparam int  IdWidth        = $clog2(NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumReq-1:0]                       req_valid_i,
    output logic [NumReq-1:0]                       req_ready_o,
    input  logic [NumReq-1:0][$bits(ReqType)-1:0]   req_data_i,
    input  logic [NumReq-1:0][UserTagWidth-1:0]     req_tag_i,
    output logic [NumReq-1:0]                       rsp_valid_o,
    input  logic [NumReq-1:0]                       rsp_ready_i,
    output logic [$bits(RspType)-1:0]               rsp_data_o,
    output logic [UserTagWidth-1:0]                 rsp_tag_o,
    input  logic                                    flush_i,
    output logic                                    fpu_in_valid_o,
    input  logic                                    fpu_in_ready_i,
    output logic [$bits(ReqType)-1:0]               fpu_req_o,
    output logic [IdWidth+UserTagWidth-1:0]         fpu_tag_o,
    input  logic                                    fpu_out_valid_i,
    output logic                                    fpu_out_ready_o,
    input  logic [$bits(RspType)-1:0]               fpu_rsp_i,
    input  logic [IdWidth+UserTagWidth-1:0]         fpu_tag_i,
    output logic                                    fpu_flush_o,
    input  logic                                    fpu_busy_i,
    output logic                                    idle_o
);

    localparam int                 TagWidth = share_tag_width(NumReq, UserTagWidth);
    localparam int                 CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);

    share_state_e        r_state;
    logic [IdWidth-1:0]  r_rr_ptr;
    logic [IdWidth-1:0]  r_lock_idx;
    logic                r_lock;
    logic [CntWidth-1:0] r_cnt;

    logic                w_issue_en;
    logic                w_sel_valid;
    logic [IdWidth-1:0]  w_sel_idx;
    logic                w_use_lock;
    logic [IdWidth-1:0]  w_gnt_idx;
    logic                w_issue_hs;
    logic [IdWidth-1:0]  w_rsp_id;
    logic                w_id_ok;
    logic                w_id_ready;
    logic                w_rsp_hs;

    fpnew_share_rr_sel #(.NumReq(NumReq)) u_rr_sel (
        .i_req       (req_valid_i),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_idx   (w_sel_idx),
        .o_gnt_valid (w_sel_valid)
    );

    // A stalled grant stays with its requester even if a higher-priority one
    // raises valid meanwhile; the lock only applies while that requester holds valid.
    assign w_use_lock = r_lock & req_valid_i[r_lock_idx];
    assign w_gnt_idx  = w_use_lock ? r_lock_idx : w_sel_idx;

    // Issue side is purely combinational; valid never looks at fpu_in_ready_i.
    assign w_issue_en     = (r_state == IDLE) & ~flush_i & (r_cnt < CntMax);
    assign fpu_in_valid_o = ~rst_i & w_issue_en & w_sel_valid;
    assign w_issue_hs     = fpu_in_valid_o & fpu_in_ready_i;
    assign fpu_req_o      = req_data_i[w_gnt_idx];
    assign fpu_tag_o      = {w_gnt_idx, req_tag_i[w_gnt_idx]};
    assign fpu_flush_o    = ~rst_i & flush_i;

    // One-hot accept towards the granted requester only.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            req_ready_o[k] = w_issue_hs & (w_gnt_idx == IdWidth'(k));
        end
    end

    // Decode the returning id; ids beyond NumReq are swallowed.
    assign w_rsp_id = fpu_tag_i[TagWidth-1 -: IdWidth];
    always_comb begin
        w_id_ok     = 1'b0;
        w_id_ready  = 1'b0;
        rsp_valid_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_rsp_id == IdWidth'(k)) begin
                w_id_ok        = 1'b1;
                w_id_ready     = rsp_ready_i[k];
                rsp_valid_o[k] = ~rst_i & fpu_out_valid_i & (r_state == IDLE);
            end
        end
    end

    assign fpu_out_ready_o = ~rst_i & ((r_state == DRAIN) | ~w_id_ok | w_id_ready);
    assign w_rsp_hs        = fpu_out_valid_i & fpu_out_ready_o & (r_state == IDLE);
    assign rsp_data_o      = fpu_rsp_i;
    assign rsp_tag_o       = fpu_tag_i[UserTagWidth-1:0];
    assign idle_o          = (r_state == IDLE) & (r_cnt == '0) & ~fpu_busy_i;

    // Phase FSM and outstanding counter; flush overrides any same-cycle +/-.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
        end else begin
            if (w_issue_hs && !w_rsp_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_issue_hs && w_rsp_hs && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == DRAIN && !fpu_busy_i && !fpu_out_valid_i) begin
                r_state <= IDLE;
            end
        end
    end

    // Round-robin pointer advances past the winner; grant lock tracks backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            if (w_issue_hs) begin
                r_rr_ptr <= (w_gnt_idx == IdWidth'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            r_lock     <= fpu_in_valid_o & ~fpu_in_ready_i;
            r_lock_idx <= w_gnt_idx;
        end
    end

`ifdef FPNEW_SHARE_ASSERT_EN
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_gnt_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (fpu_in_valid_o && !fpu_in_ready_i && !flush_i) |=>
        (!fpu_in_valid_o || !req_valid_i[$past(w_gnt_idx)] || w_gnt_idx == $past(w_gnt_idx)));
    a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
        r_cnt <= CntMax);
    a_cnt_under: assert property (@(posedge clk_i) disable iff (rst_i)
        w_rsp_hs |-> (r_cnt != '0 || w_issue_hs));
    a_id_range: assert property (@(posedge clk_i) disable iff (rst_i)
        fpu_out_valid_i |-> w_id_ok);
    a_no_rsp_drain: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == DRAIN) |-> (rsp_valid_o == '0));
`endif

endmodule
